// File: rtl/arcade_ce_pkg.sv
// arcade_ce_pkg: shared types and default constants for the arcade clock-enable
// generator.
//   ce_mode_t   : channel operating mode (integer divider or fractional accumulator)
//   CE_W        : default width of divisor/increment values and the accumulator
//   CE_RST_VAL  : default divider reload value loaded at reset
package arcade_ce_pkg;

  typedef enum logic {
    CE_DIV  = 1'b0,
    CE_FRAC = 1'b1
  } ce_mode_t;

  localparam int CE_W       = 16;
  localparam int CE_RST_VAL = 3;

endpackage

// File: rtl/arcade_ce_gen_if.sv
// arcade_ce_gen_if: configuration bus of the clock-enable generator.
//   cfg_we   : one-cycle write strobe
//   cfg_ch   : target channel (values >= NUM_CH select nothing)
//   cfg_mode : CE_DIV or CE_FRAC
//   cfg_val  : DIV reload value (period = val+1) or FRAC increment
//   cfg_busy : per-channel flag, a written configuration is waiting to be applied
//
// Handshake: there is no ready. Every cycle with cfg_we high is a complete
// write that is always accepted into the channel's pending slot; a later write
// to the same channel before it is applied replaces it. cfg_busy[ch] rises on
// the cycle after the write and falls on the edge that applies it.
// master = configuration source, slave = arcade_ce_gen.
interface arcade_ce_gen_if
  import arcade_ce_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int W      = CE_W
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  ce_mode_t          cfg_mode;
  logic [W-1:0]      cfg_val;
  logic [NUM_CH-1:0] cfg_busy;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_val, input cfg_busy);
  modport slave  (input cfg_we, cfg_ch, cfg_mode, cfg_val, output cfg_busy);

endinterface

// File: rtl/arcade_ce_channel.sv
// arcade_ce_channel: one clock-enable channel, either an integer divider or a
// fractional phase accumulator, with a pending configuration slot that is only
// applied on the channel's own event edge so the output never glitches.
//   clk_sys, reset : clock and synchronous active-high reset
//   pause          : hold all state, ce forced low, apply blocked
//   sync           : restart phase (applies any pending config first)
//   wr, wr_mode, wr_val : configuration write into the pending slot
//   ce             : registered enable pulse
//   busy           : pending configuration not yet applied
module arcade_ce_channel
  import arcade_ce_pkg::*;
#(
  parameter int W       = CE_W,
  parameter int RST_VAL = CE_RST_VAL
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         pause,
  input  logic         sync,
  input  logic         wr,
  input  ce_mode_t     wr_mode,
  input  logic [W-1:0] wr_val,
  output logic         ce,
  output logic         busy
);

  localparam logic [W-1:0] RST_V = W'(RST_VAL);
  localparam logic [W-1:0] ONE   = W'(1);

  ce_mode_t     mode, pend_mode;
  logic [W-1:0] val, cnt, acc, pend_val;
  logic         pend;
  logic [W:0]   sum;
  logic         event_now;
  logic         apply_now;

  assign sum = {1'b0, acc} + {1'b0, val};

  always_comb begin
    event_now = (mode == CE_DIV) ? (cnt == '0) : sum[W];
    // A FRAC channel with a zero increment never fires, so its pending
    // configuration is taken on the next running edge instead.
    apply_now = pend && !pause && (event_now || (mode == CE_FRAC && val == '0));
  end

  assign busy = pend;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode      <= CE_DIV;
      val       <= RST_V;
      cnt       <= RST_V;
      acc       <= '0;
      pend      <= 1'b0;
      pend_mode <= CE_DIV;
      pend_val  <= '0;
      ce        <= 1'b0;
    end else if (sync) begin
      // Restart: a pending config is applied first so the new phase starts
      // from the new values; a write on this same edge stays pending.
      ce  <= 1'b0;
      acc <= '0;
      if (pend) begin
        mode <= pend_mode;
        val  <= pend_val;
        cnt  <= pend_val;
      end else begin
        cnt <= val;
      end
      pend <= wr;
      if (wr) begin
        pend_mode <= wr_mode;
        pend_val  <= wr_val;
      end
    end else begin
      if (wr) begin
        pend      <= 1'b1;
        pend_mode <= wr_mode;
        pend_val  <= wr_val;
      end else if (apply_now) begin
        pend <= 1'b0;
      end

      if (pause) begin
        ce <= 1'b0;
      end else begin
        ce <= event_now;
        if (mode == CE_DIV) begin
          cnt <= event_now ? val : (cnt - ONE);
        end else begin
          acc <= sum[W-1:0];
        end
        // The event on this edge used the old values; later assignments
        // here override the normal advance above.
        if (apply_now) begin
          mode <= pend_mode;
          val  <= pend_val;
          if (pend_mode == CE_DIV || pend_mode != mode) begin
            cnt <= pend_val;
            acc <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/arcade_ce_gen.sv
// arcade_ce_gen: NUM_CH-channel clock-enable generator for arcade cores.
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   pause   : freeze all channels, all ce low
//   sync    : per-channel phase restart mask
//   cfg     : configuration bus (slave side), includes cfg_busy
//   ce      : registered one-cycle enable pulses
module arcade_ce_gen
  import arcade_ce_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int W       = CE_W,
  parameter int RST_VAL = CE_RST_VAL
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              pause,
  input  logic [NUM_CH-1:0] sync,
  arcade_ce_gen_if.slave    cfg,
  output logic [NUM_CH-1:0] ce
);

  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] busy;

  // Channel numbers outside 0..NUM_CH-1 match no strobe and are dropped.
  always_comb begin
    wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = cfg.cfg_we && (int'(cfg.cfg_ch) == i);
    end
  end

  assign cfg.cfg_busy = busy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    arcade_ce_channel #(
      .W       (W),
      .RST_VAL (RST_VAL)
    ) u_ch (
      .clk_sys (clk_sys),
      .reset   (reset),
      .pause   (pause),
      .sync    (sync[i]),
      .wr      (wr[i]),
      .wr_mode (cfg.cfg_mode),
      .wr_val  (cfg.cfg_val),
      .ce      (ce[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_arcade_ce_gen.sv
// tb_arcade_ce_gen: randomized and directed bench for arcade_ce_gen.
// A 4-channel instance is compared every cycle against an event-time model;
// a 3-channel instance receives writes to channel 3 only and must keep its
// reset behaviour.
module tb_arcade_ce_gen;
  import arcade_ce_pkg::*;

  localparam int RST = 3;
  localparam int MODW = 65536;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic       reset = 1'b1;
  logic       pause = 1'b0;
  logic [3:0] sync  = '0;
  logic [3:0] ce;
  logic [2:0] ce3;

  arcade_ce_gen_if #(.NUM_CH(4), .W(16)) ifm ();
  arcade_ce_gen_if #(.NUM_CH(3), .W(16)) if3 ();

  arcade_ce_gen #(.NUM_CH(4), .W(16), .RST_VAL(RST)) dut (
    .clk_sys (clk_sys), .reset (reset), .pause (pause), .sync (sync),
    .cfg (ifm), .ce (ce)
  );

  arcade_ce_gen #(.NUM_CH(3), .W(16), .RST_VAL(RST)) dut3 (
    .clk_sys (clk_sys), .reset (reset), .pause (1'b0), .sync (3'b000),
    .cfg (if3), .ce (ce3)
  );

  // ---------------- scoreboard ----------------
  logic [13:0] exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 0;
  bit  frac_win = 0;
  int  frac_cnt = 0;

  // ---------------- reference model ----------------
  // DIV channels are tracked as the absolute edge of the next event; FRAC
  // channels as the accumulated phase modulo 2^16.
  int       t = 0;
  int       lr = 0;
  ce_mode_t m_mode[4], m_pmode[4];
  int       m_val[4], m_pval[4], m_next[4], m_acc[4];
  bit       m_pend[4];

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic p, input logic [3:0] s,
                      input logic we, input logic [1:0] ch,
                      input ce_mode_t md, input logic [15:0] v);
    logic [3:0] e_ce, e_busy;
    logic [2:0] e_ce3;
    bit ev, ap, wr_i;
    reset = r; pause = p; sync = s;
    ifm.cfg_we = we; ifm.cfg_ch = ch; ifm.cfg_mode = md; ifm.cfg_val = v;
    if3.cfg_we   = ($urandom_range(0, 3) == 0);
    if3.cfg_ch   = 2'd3;
    if3.cfg_mode = ce_mode_t'($urandom_range(0, 1));
    if3.cfg_val  = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 4; i++) begin
      wr_i = we && (ch == i[1:0]);
      ev = 0;
      ap = 0;
      if (r) begin
        m_mode[i] = CE_DIV; m_val[i] = RST; m_next[i] = t + RST + 1;
        m_acc[i] = 0; m_pend[i] = 0; e_ce[i] = 1'b0;
      end else if (s[i]) begin
        if (m_pend[i]) begin m_mode[i] = m_pmode[i]; m_val[i] = m_pval[i]; end
        m_next[i] = t + m_val[i] + 1;
        m_acc[i]  = 0;
        e_ce[i]   = 1'b0;
        m_pend[i] = wr_i;
        if (wr_i) begin m_pmode[i] = md; m_pval[i] = int'(v); end
      end else begin
        if (p) begin
          e_ce[i] = 1'b0;
          m_next[i]++;
        end else begin
          if (m_mode[i] == CE_DIV) begin
            ev = (t == m_next[i]);
            if (ev) m_next[i] = t + m_val[i] + 1;
          end else begin
            ev = (m_acc[i] + m_val[i] >= MODW);
            m_acc[i] = (m_acc[i] + m_val[i]) % MODW;
          end
          e_ce[i] = ev;
          ap = m_pend[i] && (ev || (m_mode[i] == CE_FRAC && m_val[i] == 0));
          if (ap) begin
            if (m_pmode[i] == CE_DIV) m_next[i] = t + m_pval[i] + 1;
            else if (m_mode[i] == CE_DIV) m_acc[i] = 0;
            m_mode[i] = m_pmode[i];
            m_val[i]  = m_pval[i];
          end
        end
        if (wr_i) begin m_pend[i] = 1; m_pmode[i] = md; m_pval[i] = int'(v); end
        else if (ap) m_pend[i] = 0;
      end
      e_busy[i] = m_pend[i];
    end
    if (r) begin
      lr = t;
      e_ce3 = 3'b000;
    end else begin
      e_ce3 = ((t - lr) % 4 == 0) ? 3'b111 : 3'b000;
    end
    exp_q.push_back({3'b000, e_ce3, e_busy, e_ce});
    mon_en = 1;
    t++;
    @(negedge clk_sys);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 4'b0000, 0, 2'd0, CE_DIV, 16'd0);
  endtask

  task automatic wr(input logic [1:0] ch, input ce_mode_t md, input logic [15:0] v);
    step(0, 0, 4'b0000, 1, ch, md, v);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk_sys) begin
    if (mon_en) begin
      logic [13:0] e, a;
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL no_expected check=%0d", n_checks);
      end else begin
        e = exp_q.pop_front();
        a = {if3.cfg_busy, ce3, ifm.cfg_busy, ce};
        if (a !== e) begin
          n_fail++;
          $display("FAIL ce_busy check=%0d busy3/ce3/busy/ce got=%b required=%b",
                   n_checks, a, e);
        end
        if (frac_win && ce[0]) frac_cnt++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] s;
    ce_mode_t   md;
    logic [15:0] v;
    ifm.cfg_we = 0; ifm.cfg_ch = 0; ifm.cfg_mode = CE_DIV; ifm.cfg_val = 0;
    if3.cfg_we = 0; if3.cfg_ch = 0; if3.cfg_mode = CE_DIV; if3.cfg_val = 0;
    @(negedge clk_sys);

    // reset defaults
    for (int k = 0; k < 3; k++) step(1, 0, 4'b0000, 0, 2'd0, CE_DIV, 16'd0);
    idle(5);
    // glitch-free DIV reload on ch2 at cycle 5
    wr(2'd2, CE_DIV, 16'd13);
    idle(40);
    // FRAC quarter rate on ch1, then realign it
    wr(2'd1, CE_FRAC, 16'h4000);
    idle(8);
    step(0, 0, 4'b0010, 0, 2'd0, CE_DIV, 16'd0);
    idle(24);
    // FRAC 0x5555 on ch0: count pulses in 768 cycles after sync
    wr(2'd0, CE_FRAC, 16'h5555);
    idle(6);
    step(0, 0, 4'b0001, 0, 2'd0, CE_DIV, 16'd0);
    frac_win = 1;
    idle(768);
    frac_win = 0;
    n_checks++;
    if (frac_cnt != 255) begin
      n_fail++;
      $display("FAIL frac_5555_count got=%0d required=255", frac_cnt);
    end
    // pause for 10 cycles with a blocked write to ch3
    wr(2'd3, CE_DIV, 16'd9);
    idle(20);
    for (int k = 0; k < 10; k++)
      step(0, 1, 4'b0000, (k == 3), 2'd3, CE_DIV, 16'd5);
    idle(20);
    // sync ch0/ch1 while paused (put ch0/ch1 back to DIV first)
    wr(2'd0, CE_DIV, 16'd6);
    wr(2'd1, CE_DIV, 16'd6);
    idle(20);
    for (int k = 0; k < 10; k++)
      step(0, 1, (k == 4) ? 4'b0011 : 4'b0000, 0, 2'd0, CE_DIV, 16'd0);
    idle(20);
    // write then reset on the next edge
    wr(2'd2, CE_FRAC, 16'h1234);
    step(1, 0, 4'b0000, 0, 2'd0, CE_DIV, 16'd0);
    idle(12);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 39) == 0);
      md = ce_mode_t'($urandom_range(0, 1));
      if (md == CE_DIV) v = 16'($urandom_range(0, 12));
      else v = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0), s,
           ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), md, v);
    end

    mon_en = 0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
